// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding, used by both the receiver
// and the matching transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS          = 8;
  localparam int UART_OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic parity_mismatch(input logic [UART_DATA_BITS-1:0] i_data,
                                           input logic                      i_par);
    return ^{i_data, i_par};
  endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for an asynchronous level input; flops reset to 1 so an
// idle-high line does not produce a false edge when reset is released.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) r_sync <= '1;
    else       r_sync <= {r_sync[STAGES-2:0], i_async};
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// Oversampled UART receive FSM with a one-entry valid/ready output register
// carrying parity, framing and overrun status.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = UART_OVERSAMPLE_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       parity_en,
  input  logic       rx_uart,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  input  logic       rx_data_ready,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       busy
);

  localparam int             CW      = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]  HALF_M1 = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0]  FULL_M1 = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]     LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      w_rxs;
  uart_rx_state_t            r_state;
  logic [CW-1:0]             r_cnt;
  logic [2:0]                r_bit;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_par_en;
  logic                      r_par_bad;
  logic                      r_busy;
  logic [UART_DATA_BITS-1:0] r_data;
  logic                      r_valid;
  logic                      r_perr;
  logic                      r_ferr;
  logic                      r_ovr;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (rx_uart),
    .o_sync  (w_rxs)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_par_en  <= 1'b0;
      r_par_bad <= 1'b0;
      r_busy    <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      r_cnt <= r_cnt + CW'(1);
      if (r_valid && rx_data_ready) r_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (!w_rxs) begin
            r_state   <= START;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_par_en  <= parity_en;
            r_par_bad <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (w_rxs) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_shift <= {w_rxs, r_shift[UART_DATA_BITS-1:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == LAST_BIT) r_state <= r_par_en ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (r_cnt == FULL_M1) begin
            r_cnt     <= '0;
            r_par_bad <= parity_mismatch(r_shift, w_rxs);
            r_state   <= STOP;
          end
        end
        STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt <= '0;
            // Accept into the holding register only if it is empty or draining now.
            if (!r_valid || rx_data_ready) begin
              r_data  <= r_shift;
              r_perr  <= r_par_bad;
              r_ferr  <= !w_rxs;
              r_valid <= 1'b1;
            end else begin
              r_ovr <= 1'b1;
            end
            // Leaving mid-stop-bit lets the next start edge be caught on time.
            if (w_rxs) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (w_rxs) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data       = r_data;
  assign rx_data_valid = r_valid;
  assign rx_parity_err = r_perr;
  assign rx_frame_err  = r_ferr;
  assign rx_overrun    = r_ovr;
  assign busy          = r_busy;

endmodule
